// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register byte offsets and control/status
// bit positions.
package apb_timer_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_PSC    = 8'h04;
  localparam logic [7:0] REG_ARR    = 8'h08;
  localparam logic [7:0] REG_CNT    = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_OVF = 0;

  localparam int PSC_W = 16;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: counts enabled cycles and emits a one-cycle tick each time
// the count reaches the programmed divider, then restarts from zero.
module timer_prescaler
  import apb_timer_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] count;

  assign tick = en && (count == psc);

  // Clear has priority over counting so a CLR write always restarts the period.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tick) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB slave timer: prescaled up-counter with auto-reload value, sticky overflow
// flag and a level interrupt gated by the interrupt enable.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              irq
);

  logic             ctrlEn;
  logic             ctrlIe;
  logic [PSC_W-1:0] psc;
  logic [31:0]      arr;
  logic [31:0]      cnt;
  logic             ovf;

  logic              access;
  logic              wrAccess;
  logic              rdAccess;
  logic [ADDR_W-1:0] regAddr;
  logic              selCtrl;
  logic              selPsc;
  logic              selArr;
  logic              selCnt;
  logic              selStatus;
  logic              clr;
  logic              tick;
  logic              wrap;

  assign access   = PSEL & PENABLE;
  assign wrAccess = access & PWRITE;
  assign rdAccess = access & ~PWRITE;
  assign PREADY   = access;

  // Byte-lane bits are dropped so any address within a word hits that register.
  assign regAddr   = {PADDR[ADDR_W-1:2], 2'b00};
  assign selCtrl   = (regAddr == ADDR_W'(REG_CTRL));
  assign selPsc    = (regAddr == ADDR_W'(REG_PSC));
  assign selArr    = (regAddr == ADDR_W'(REG_ARR));
  assign selCnt    = (regAddr == ADDR_W'(REG_CNT));
  assign selStatus = (regAddr == ADDR_W'(REG_STATUS));

  assign clr  = wrAccess & selCtrl & PWDATA[CTRL_CLR];
  assign wrap = (cnt >= arr);

  timer_prescaler prescaler (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .en     (ctrlEn),
    .clr    (clr),
    .psc    (psc),
    .tick   (tick)
  );

  // A tick overflow beats a same-cycle W1C, and a CLR suppresses the overflow.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrlEn <= 1'b0;
      ctrlIe <= 1'b0;
      psc    <= '0;
      arr    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wrAccess && selCtrl) begin
        ctrlEn <= PWDATA[CTRL_EN];
        ctrlIe <= PWDATA[CTRL_IE];
      end
      if (wrAccess && selPsc) psc <= PWDATA[PSC_W-1:0];
      if (wrAccess && selArr) arr <= PWDATA;

      if (clr)       cnt <= '0;
      else if (tick) cnt <= wrap ? 32'd0 : cnt + 32'd1;

      if (tick && !clr && wrap)                            ovf <= 1'b1;
      else if (wrAccess && selStatus && PWDATA[STATUS_OVF]) ovf <= 1'b0;
    end
  end

  assign irq = ovf & ctrlIe;

  always_comb begin
    PRDATA = 32'h0;
    if (rdAccess) begin
      if (selCtrl) begin
        PRDATA[CTRL_EN] = ctrlEn;
        PRDATA[CTRL_IE] = ctrlIe;
      end else if (selPsc) begin
        PRDATA[PSC_W-1:0] = psc;
      end else if (selArr) begin
        PRDATA = arr;
      end else if (selCnt) begin
        PRDATA = cnt;
      end else if (selStatus) begin
        PRDATA[STATUS_OVF] = ovf;
      end
    end
  end

endmodule
